adc_scan_scheduler: RTL and testbench
=====================================

# adc_scan_scheduler

Sequences periodic multi-channel acquisitions for the serial ADC peripheral and streams tagged results into a circular sample buffer in block RAM. It sits on the CPU peripheral bus as one chip-select slot (8-bit register file), drives the ADC peripheral's conversion request/acknowledge port, and raises an interrupt each time half of the buffer has been filled.

## Interface
- CH_BITS, 3, channel index width; 2^CH_BITS channels
- DATA_W, 10, conversion result width; must be ≤ 16 - CH_BITS
- BUF_AW, 10, sample buffer address width
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- cs  in  1  register slot select
- we  in  1  one-cycle write strobe, qualified by cs
- addr  in  3  register index
- wrBus  in  8  write data
- rdBus  out  8  read data, combinational from addr
- conv_req  out  1  conversion request, held until acknowledged
- conv_ch  out  CH_BITS  channel to convert, stable while conv_req=1
- conv_ack  in  1  one-cycle pulse, conv_data valid in the same cycle
- conv_data  in  DATA_W  conversion result
- buf_we  out  1  buffer write strobe, one cycle per sample
- buf_addr  out  BUF_AW  buffer write address
- buf_data  out  16  {conv_ch, zero pad, conv_data}; channel in bits 15:16-CH_BITS
- irq  out  1  level interrupt: irq_pend & IE

## Operation
- Registers (addr): 0 CTRL {bit0 EN, bit1 ONESHOT, bit2 IE, bit7 CLR write-1, reads 0}; 1 CHMASK; 2 PERIOD[7:0]; 3 PERIOD[15:8]; 4 STATUS {bit0 busy, bit1 irq_pend, bit2 overrun} read-only; 5 WPTR[7:0]; 6 WPTR high bits, zero-extended; 7 reads 0. Writes with cs&we; effect next cycle.
- Period timer: 16-bit down-counter. Loaded with PERIOD when EN goes 0→1; when EN=1 and count=0, emits tick and reloads. Tick every PERIOD+1 cycles. EN=0 freezes timer.
- FSM IDLE, SCAN, REQ, STORE.
  - IDLE: on tick, pending ← CHMASK, go SCAN. busy=0 only in IDLE.
  - SCAN: lowest set bit of pending → conv_ch, clear that bit, go REQ; pending empty → IDLE (if ONESHOT, EN cleared in this cycle).
  - REQ: conv_req=1; on conv_ack capture data, conv_req=0 next cycle, go STORE.
  - STORE: buf_we=1 at WPTR, WPTR+1 mod 2^BUF_AW; go SCAN, or IDLE if EN=0.
- CHMASK=0: tick → SCAN → IDLE, no request, no write.
- Tick while not IDLE: dropped, overrun←1 (sticky).
- EN cleared mid-scan: outstanding request still waits for ack and its sample is stored; then IDLE.
- irq_pend set (sticky) on a STORE writing address 2^(BUF_AW-1)-1 or 2^BUF_AW-1.
- CLR: WPTR←0, irq_pend←0, overrun←0. Same cycle as STORE: write occurs at old WPTR, CLR wins for pointer and flags.
- CHMASK/PERIOD writes mid-scan do not affect the current scan; PERIOD applies at next reload.

## Timing
- Reset values: rdBus reflects zeroed registers, conv_req=0, conv_ch=0, buf_we=0, buf_addr=0, buf_data=0, irq=0; state IDLE, timer 0.
- Tick at cycle t → SCAN at t+1 → conv_req=1 from t+2.
- Ack at cycle a → conv_req=0 and STORE (buf_we=1) at a+1 → next conv_req at a+3.
- Ack in the same cycle conv_req first rises is legal.
- Per-sample overhead: 3 cycles plus ADC ack latency.
- Reset mid-operation: outputs drop asynchronously; an in-flight ack after reset is ignored.

## Test plan
- Reset, then EN=1, CHMASK=0x05, PERIOD=99, ack 20 cycles after each request → requests ch0 then ch2 every 100 cycles; buf_data=0x0000|d0 at addr 0, 0x4000|d2 at addr 1.
- ONESHOT=1, CHMASK=0xFF → exactly 8 stores (ch0..7), EN reads 0 afterwards, no further requests.
- PERIOD=5, CHMASK=0x01, ack latency 10 → overrun=1 in STATUS, no sample lost or duplicated per started scan.
- BUF_AW=4, continuous capture → irq after stores to addr 7 and 15, buf_addr wraps 15→0; CLR drops irq and WPTR=0.
- CHMASK=0 with EN=1 → busy pulses one cycle per tick, conv_req and buf_we never asserted.
- Assert reset while conv_req=1, then ack → conv_req=0 immediately, no buf_we, all registers zero.

Source files
------------

// File: rtl/adc_scan_scheduler.sv
// rtl/adc_scan_scheduler.sv - periodic multi-channel ADC scan sequencer feeding a circular sample buffer
// Register slot on the CPU bus, conversion request/ack port towards the ADC, half-buffer interrupt.
module adc_scan_scheduler #(
  parameter int CH_BITS = 3,
  parameter int DATA_W  = 10,
  parameter int BUF_AW  = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cs,
  input  logic                we,
  input  logic [2:0]          addr,
  input  logic [7:0]          wrBus,
  output logic [7:0]          rdBus,
  output logic                conv_req,
  output logic [CH_BITS-1:0]  conv_ch,
  input  logic                conv_ack,
  input  logic [DATA_W-1:0]   conv_data,
  output logic                buf_we,
  output logic [BUF_AW-1:0]   buf_addr,
  output logic [15:0]         buf_data,
  output logic                irq
);

  localparam int NCH = 1 << CH_BITS;

  typedef enum logic [1:0] {IDLE, SCAN, REQ, STORE} state_e;

  state_e              state_q, state_d;
  logic                en_q, en_d;
  logic                en_prev_q;
  logic                oneshot_q, oneshot_d;
  logic                ie_q, ie_d;
  logic [NCH-1:0]      chmask_q, chmask_d;
  logic [15:0]         period_q, period_d;
  logic [15:0]         timer_q, timer_d;
  logic [NCH-1:0]      pending_q, pending_d;
  logic [CH_BITS-1:0]  ch_q, ch_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [BUF_AW-1:0]   wptr_q, wptr_d;
  logic                irq_pend_q, irq_pend_d;
  logic                overrun_q, overrun_d;

  logic                tick;
  logic                busy;
  logic                load_pending;
  logic                pick;
  logic                capture;
  logic                scan_done;
  logic                store;
  logic                wr_ctrl, wr_chmask, wr_per_lo, wr_per_hi;
  logic                clr;
  logic [CH_BITS-1:0]  low_idx;
  logic [15:0]         wptr_ext;
  logic [15:0]         bd;

  always_comb begin
    wr_ctrl   = cs && we && (addr == 3'd0);
    wr_chmask = cs && we && (addr == 3'd1);
    wr_per_lo = cs && we && (addr == 3'd2);
    wr_per_hi = cs && we && (addr == 3'd3);
    clr       = wr_ctrl && wrBus[7];
  end

  // Reload on the EN rising edge, so the first tick arrives PERIOD+1 cycles after enabling.
  always_comb begin
    timer_d = timer_q;
    tick    = 1'b0;
    if (en_q) begin
      if (!en_prev_q) begin
        timer_d = period_q;
      end else if (timer_q == 16'd0) begin
        tick    = 1'b1;
        timer_d = period_q;
      end else begin
        timer_d = timer_q - 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (tick) state_d = SCAN;
      SCAN:    state_d = (pending_q == '0) ? IDLE : REQ;
      REQ:     if (conv_ack) state_d = STORE;
      STORE:   state_d = en_q ? SCAN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    conv_req     = (state_q == REQ);
    store        = (state_q == STORE);
    busy         = (state_q != IDLE);
    load_pending = (state_q == IDLE) && tick;
    pick         = (state_q == SCAN) && (pending_q != '0);
    scan_done    = (state_q == SCAN) && (pending_q == '0);
    capture      = (state_q == REQ) && conv_ack;
  end

  always_comb begin
    low_idx = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (pending_q[i]) low_idx = CH_BITS'(i);
    end
  end

  always_comb begin
    en_d       = en_q;
    oneshot_d  = oneshot_q;
    ie_d       = ie_q;
    chmask_d   = chmask_q;
    period_d   = period_q;
    pending_d  = pending_q;
    ch_d       = ch_q;
    data_d     = data_q;
    wptr_d     = wptr_q;
    irq_pend_d = irq_pend_q;
    overrun_d  = overrun_q;

    if (load_pending) pending_d = chmask_q;
    if (pick) begin
      ch_d      = low_idx;
      pending_d = pending_q & (pending_q - NCH'(1));
    end
    if (capture) data_d = conv_data;
    if (scan_done && oneshot_q) en_d = 1'b0;
    if (tick && busy) overrun_d = 1'b1;
    if (store) begin
      wptr_d = wptr_q + BUF_AW'(1);
      if (&wptr_q[BUF_AW-2:0]) irq_pend_d = 1'b1;
    end

    // CPU writes land last so CLR beats a coincident store or overrun.
    if (wr_ctrl) begin
      en_d      = wrBus[0];
      oneshot_d = wrBus[1];
      ie_d      = wrBus[2];
    end
    if (wr_chmask) chmask_d = wrBus[NCH-1:0];
    if (wr_per_lo) period_d[7:0] = wrBus;
    if (wr_per_hi) period_d[15:8] = wrBus;
    if (clr) begin
      wptr_d     = '0;
      irq_pend_d = 1'b0;
      overrun_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_q       <= 1'b0;
      en_prev_q  <= 1'b0;
      oneshot_q  <= 1'b0;
      ie_q       <= 1'b0;
      chmask_q   <= '0;
      period_q   <= '0;
      timer_q    <= '0;
      pending_q  <= '0;
      ch_q       <= '0;
      data_q     <= '0;
      wptr_q     <= '0;
      irq_pend_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      en_q       <= en_d;
      en_prev_q  <= en_q;
      oneshot_q  <= oneshot_d;
      ie_q       <= ie_d;
      chmask_q   <= chmask_d;
      period_q   <= period_d;
      timer_q    <= timer_d;
      pending_q  <= pending_d;
      ch_q       <= ch_d;
      data_q     <= data_d;
      wptr_q     <= wptr_d;
      irq_pend_q <= irq_pend_d;
      overrun_q  <= overrun_d;
    end
  end

  always_comb begin
    wptr_ext = 16'(wptr_q);
    case (addr)
      3'd0:    rdBus = {5'b0, ie_q, oneshot_q, en_q};
      3'd1:    rdBus = 8'(chmask_q);
      3'd2:    rdBus = period_q[7:0];
      3'd3:    rdBus = period_q[15:8];
      3'd4:    rdBus = {5'b0, overrun_q, irq_pend_q, busy};
      3'd5:    rdBus = wptr_ext[7:0];
      3'd6:    rdBus = wptr_ext[15:8];
      default: rdBus = 8'h00;
    endcase
  end

  always_comb begin
    bd                = '0;
    bd[DATA_W-1:0]    = data_q;
    bd[15 -: CH_BITS] = ch_q;
  end

  assign conv_ch  = ch_q;
  assign buf_we   = store;
  assign buf_addr = wptr_q;
  assign buf_data = bd;
  assign irq      = irq_pend_q & ie_q;

endmodule

// File: tb/tb_adc_scan_scheduler.sv
// tb/tb_adc_scan_scheduler.sv - directed self-checking bench for adc_scan_scheduler
// Runs with a 16-entry buffer so the half/full interrupt points and the wrap are reachable quickly.
module tb_adc_scan_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        cs, we;
  logic [2:0]  addr;
  logic [7:0]  wrBus;
  logic [7:0]  rdBus;
  logic        conv_req;
  logic [2:0]  conv_ch;
  logic        conv_ack;
  logic [9:0]  conv_data;
  logic        buf_we;
  logic [3:0]  buf_addr;
  logic [15:0] buf_data;
  logic        irq;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int nwe = 0;
  int nreq = 0;
  logic req_prev = 1'b0;
  int last_wait;

  adc_scan_scheduler #(.CH_BITS(3), .DATA_W(10), .BUF_AW(4)) dut (
    .clk(clk), .reset(reset), .cs(cs), .we(we), .addr(addr), .wrBus(wrBus), .rdBus(rdBus),
    .conv_req(conv_req), .conv_ch(conv_ch), .conv_ack(conv_ack), .conv_data(conv_data),
    .buf_we(buf_we), .buf_addr(buf_addr), .buf_data(buf_data), .irq(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (buf_we === 1'b1) nwe <= nwe + 1;
    if (conv_req === 1'b1 && req_prev !== 1'b1) nreq <= nreq + 1;
    req_prev <= conv_req;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick1();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    cs = 1'b1; we = 1'b1; addr = a; wrBus = d;
    tick1();
    cs = 1'b0; we = 1'b0; wrBus = 8'h00;
  endtask

  task automatic rd(input logic [2:0] a, output logic [7:0] d);
    addr = a;
    #1;
    d = rdBus;
  endtask

  task automatic wait_req();
    int n = 0;
    while (conv_req !== 1'b1 && n < 400) begin
      tick1();
      n++;
    end
    last_wait = n;
    chk("req_arrives", 32'(conv_req), 32'd1);
  endtask

  // Answer one request after lat cycles and check the resulting buffer write.
  task automatic serve(input logic [2:0] ch, input int lat, input logic [9:0] d, input logic [3:0] a);
    logic [15:0] exp_bd;
    wait_req();
    chk("conv_ch", 32'(conv_ch), 32'(ch));
    repeat (lat - 1) tick1();
    conv_data = d;
    conv_ack = 1'b1;
    tick1();
    conv_ack = 1'b0;
    exp_bd = {ch, 3'b000, d};
    chk("req_drop", 32'(conv_req), 32'd0);
    chk("buf_we", 32'(buf_we), 32'd1);
    chk("buf_addr", 32'(buf_addr), 32'(a));
    chk("buf_data", 32'(buf_data), 32'(exp_bd));
  endtask

  initial begin
    logic [7:0] r;
    int t1, t2, we0, rq0, busy_n, req_n, bwe_n;

    reset = 1'b1; cs = 1'b0; we = 1'b0; addr = 3'd0; wrBus = 8'h00;
    conv_ack = 1'b0; conv_data = 10'h000;
    repeat (3) tick1();
    reset = 1'b0;
    tick1();
    for (int i = 0; i < 8; i++) begin
      rd(3'(i), r);
      chk("reset_reg", 32'(r), 32'd0);
    end
    chk("reset_req", 32'(conv_req), 32'd0);
    chk("reset_ch", 32'(conv_ch), 32'd0);
    chk("reset_bwe", 32'(buf_we), 32'd0);
    chk("reset_baddr", 32'(buf_addr), 32'd0);
    chk("reset_bdata", 32'(buf_data), 32'd0);
    chk("reset_irq", 32'(irq), 32'd0);

    // Periodic scan of ch0 and ch2, period 99
    wr(3'd1, 8'h05);
    wr(3'd2, 8'd99);
    wr(3'd3, 8'h00);
    wr(3'd0, 8'h01);
    serve(3'd0, 20, 10'h155, 4'd0);
    chk("first_req_latency", 32'(last_wait), 32'd102);
    t1 = cyc - 21;
    serve(3'd2, 20, 10'h2AA, 4'd1);
    chk("next_req_latency", 32'(last_wait), 32'd2);
    serve(3'd0, 20, 10'h001, 4'd2);
    t2 = cyc - 21;
    chk("scan_period", 32'(t2 - t1), 32'd100);
    serve(3'd2, 20, 10'h3FF, 4'd3);
    tick1();
    rd(3'd5, r);
    chk("wptr_after_4", 32'(r), 32'd4);
    wr(3'd0, 8'h80);
    tick1();
    rd(3'd4, r);
    chk("status_after_clr", 32'(r), 32'd0);
    rd(3'd5, r);
    chk("wptr_after_clr", 32'(r), 32'd0);

    // One-shot scan of all 8 channels
    wr(3'd1, 8'hFF);
    wr(3'd0, 8'h03);
    for (int i = 0; i < 8; i++) serve(3'(i), 3, 10'h300 + 10'(i), 4'(i));
    tick1();
    tick1();
    rd(3'd0, r);
    chk("oneshot_en_cleared", 32'(r), 32'h02);
    rd(3'd4, r);
    chk("oneshot_status", 32'(r), 32'h02);
    chk("irq_masked", 32'(irq), 32'd0);
    we0 = nwe; rq0 = nreq;
    repeat (150) tick1();
    chk("oneshot_no_more_we", 32'(nwe - we0), 32'd0);
    chk("oneshot_no_more_req", 32'(nreq - rq0), 32'd0);

    // Overrun: period 5 with slow ADC
    wr(3'd0, 8'h80);
    wr(3'd1, 8'h01);
    wr(3'd2, 8'd5);
    we0 = nwe; rq0 = nreq;
    wr(3'd0, 8'h01);
    serve(3'd0, 10, 10'h111, 4'd0);
    serve(3'd0, 10, 10'h222, 4'd1);
    serve(3'd0, 10, 10'h333, 4'd2);
    wr(3'd0, 8'h00);
    tick1();
    rd(3'd4, r);
    chk("overrun_status", 32'(r), 32'h04);
    repeat (30) tick1();
    chk("overrun_stores", 32'(nwe - we0), 32'd3);
    chk("overrun_reqs", 32'(nreq - rq0), 32'd3);
    rd(3'd5, r);
    chk("overrun_wptr", 32'(r), 32'd3);

    // Continuous capture: interrupt at half buffer, wrap 15 -> 0
    wr(3'd1, 8'h03);
    wr(3'd0, 8'h85);
    for (int i = 0; i < 18; i++) begin
      serve(3'(i % 2), 2, 10'(i * 37), 4'(i % 16));
      if (i == 6) chk("irq_before_half", 32'(irq), 32'd0);
      if (i == 7) begin
        tick1();
        chk("irq_at_half", 32'(irq), 32'd1);
      end
    end
    chk("irq_after_wrap", 32'(irq), 32'd1);
    wr(3'd0, 8'h84);
    tick1();
    rd(3'd4, r);
    chk("clr_status", 32'(r), 32'd0);
    chk("clr_irq", 32'(irq), 32'd0);
    rd(3'd5, r);
    chk("clr_wptr", 32'(r), 32'd0);

    // Empty channel mask: busy blips only
    wr(3'd1, 8'h00);
    wr(3'd2, 8'd9);
    wr(3'd0, 8'h01);
    addr = 3'd4;
    busy_n = 0; req_n = 0; bwe_n = 0;
    for (int i = 0; i < 100; i++) begin
      tick1();
      if (rdBus[0] === 1'b1) busy_n++;
      if (conv_req === 1'b1) req_n++;
      if (buf_we === 1'b1) bwe_n++;
    end
    chk("empty_mask_busy", 32'(busy_n), 32'd9);
    chk("empty_mask_req", 32'(req_n), 32'd0);
    chk("empty_mask_we", 32'(bwe_n), 32'd0);

    // Reset while a request is outstanding
    wr(3'd1, 8'h01);
    wait_req();
    we0 = nwe;
    reset = 1'b1;
    #1;
    chk("async_req_drop", 32'(conv_req), 32'd0);
    chk("async_we", 32'(buf_we), 32'd0);
    tick1();
    reset = 1'b0;
    conv_data = 10'h0AB;
    conv_ack = 1'b1;
    tick1();
    conv_ack = 1'b0;
    tick1();
    chk("post_reset_req", 32'(conv_req), 32'd0);
    chk("post_reset_we", 32'(nwe - we0), 32'd0);
    chk("post_reset_bdata", 32'(buf_data), 32'd0);
    for (int i = 0; i < 8; i++) begin
      rd(3'(i), r);
      chk("post_reset_reg", 32'(r), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
